shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
//
// PURPOSE
// - Shares one DATA_W-bit D-flip-flop register between NUM_REQ write requesters.
// - Each requester raises a request with its write data. The block grants one requester at a time,
//   round-robin, and loads its data into the shared register.
// - Sits between the requester logic and the register bank, so dff storage is never written
//   by two sources in one cycle.
//
// PARAMETERS
// - NUM_REQ    4     number of requesters, 2..16
// - DATA_W     8     shared register width
// - RESET_VAL  '0    value of q after reset
//
// PORTS
// - clk      in   1               single clock; all state on rising edge
// - rst      in   1               asynchronous, active-high reset
// - req      in   NUM_REQ         per-requester write request; level, held until done or abandoned
// - wdata    in   NUM_REQ*DATA_W  requester k data in bits [k*DATA_W +: DATA_W]
// - gnt      out  NUM_REQ         one-hot grant, registered
// - done     out  1               one-cycle pulse: write committed
// - owner    out  $clog2(NUM_REQ) index of the current or last granted requester
// - busy     out  1               high in GRANT and COMMIT
// - q        out  DATA_W          shared register contents
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - gnt=0, done=0, busy=0, owner=0, q=RESET_VAL, state=IDLE.
//   - Round-robin pointer last=NUM_REQ-1, so req[0] has highest priority first.
// - FSM states: IDLE, GRANT, COMMIT.
// - IDLE:
//   - If req!=0: winner = first set bit searching from last+1 upward, with wrap-around.
//   - On the next edge: state=GRANT, gnt=onehot(winner), owner=winner, busy=1.
//   - Otherwise stay in IDLE.
// - GRANT (exactly 1 cycle):
//   - If req[owner]=1 at the edge: q <= wdata[owner]; state=COMMIT; done<=1.
//   - If req[owner]=0 (abandoned): q unchanged; state=IDLE; no done pulse.
//   - In both cases: gnt<=0, last<=owner.
// - COMMIT (exactly 1 cycle):
//   - done=1, q shows the new value; next edge: done<=0, busy<=0, state=IDLE.
// - Latency: req seen at edge N -> gnt high during N..N+1 -> q and done valid after edge N+1.
// - Throughput: at most one write per 3 cycles.
// - Requesters other than the owner are ignored while busy. Their req stays pending and no data
//   is lost, because sampling happens only in GRANT.
// - The requester must hold req until done. Dropping req after done is its own responsibility.
//   If req stays high, it competes again, but is lowest priority next round.
// - Simultaneous requests: the pointer guarantees each requester is granted within NUM_REQ rounds.
// - Any rst assertion mid-operation:
//   - Forces IDLE immediately, with gnt=0 and done=0.
//   - Sets q=RESET_VAL; an in-flight write is discarded.
// - gnt is never more than one-hot, and is never high outside GRANT.
// - wdata of non-owners never affects q.
//
// STRUCTURE
// - Package shared_reg_pkg:
//   - typedef enum logic [1:0] {IDLE, GRANT, COMMIT} sr_state_t.
//   - function onehot(idx).
//   - localparam IDX_W = $clog2(NUM_REQ).
// - Sub-module rr_pick: combinational round-robin selector.
//   - Inputs: req and last.
//   - Outputs: any and idx.
//   - Implemented as a double-width masked priority encode.
// - Top level: FSM, pointer register, owner/gnt/done registers, and the q data register
//   (the shared dff bank).
//
// TESTING
// - Reset: rst=1 mid-run with req=4'b1111
//   -> gnt=0, done=0, busy=0, q=RESET_VAL within the same cycle, without waiting for a clock edge.
// - Single request: req=4'b0100, wdata[2]=8'hA5
//   -> gnt=4'b0100 for 1 cycle, then done=1 with q=8'hA5, owner=2, busy drops next cycle.
// - Fairness: req=4'b1111 held with distinct data
//   -> grants in order 0,1,2,3,0 with one done per 3 cycles; q tracks each owner's data.
// - Wrap-around: last=3, req=4'b1001 -> req[0] granted first, then req[3].
// - Abandon: owner drops req during GRANT
//   -> q unchanged, no done, IDLE next cycle, next grant goes to the following requester.
// - Non-owner isolation: change wdata[1] while req[2] is granted -> q equals wdata[2] only.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter.
// Contents:
//   sr_state_t  - arbiter FSM states (IDLE, GRANT, COMMIT)
//   MAX_REQ     - largest supported requester count
//   MAX_IDX_W   - index width that covers MAX_REQ requesters
//   IDX_W       - index width for the default four-requester build
//   onehot()    - index to one-hot decode, MAX_REQ bits wide
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } sr_state_t;

  localparam int MAX_REQ     = 16;
  localparam int MAX_IDX_W   = 4;
  localparam int NUM_REQ_DEF = 4;
  localparam int IDX_W       = $clog2(NUM_REQ_DEF);

  // The caller slices the low NUM_REQ bits from the result.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the write requesters and the shared-register arbiter.
// Signals:
//   req    - per-requester write request (level)
//   wdata  - requester k data in bits [k*DATA_W +: DATA_W]
//   gnt    - registered one-hot grant
//   done   - one-cycle pulse when a write has been committed
//   owner  - index of the current or last granted requester
//   busy   - arbiter is in a grant/commit sequence
//   q      - shared register contents
// Modports:
//   master - requester side (drives req/wdata)
//   slave  - arbiter side (drives gnt/done/owner/busy/q)
interface shared_reg_arbiter_if
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic                      done;
  logic [SEL_W-1:0]          owner;
  logic                      busy;
  logic [DATA_W-1:0]         q;

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  done,
    input  owner,
    input  busy,
    input  q
  );

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output done,
    output owner,
    output busy,
    output q
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Picks the first asserted request above 'last', wrapping around to bit 0.
// Ports:
//   req   in   NUM_REQ  request vector
//   last  in   SEL_W    index granted most recently (lowest priority now)
//   any   out  1        at least one request is pending
//   idx   out  SEL_W    index of the winning request (0 when any=0)
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0]   above;
  logic [2*NUM_REQ-1:0] dbl;

  // Lower half holds only the requests strictly above 'last'; upper half
  // holds all requests and catches the wrap-around. The lowest set bit of
  // the doubled vector is the round-robin winner.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      above[i] = (i > int'(last));
    end
    dbl = {req, req & above};
    any = |req;
    idx = '0;
    // Scan downward so that the lowest set bit is written last and wins.
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dbl[i]) begin
        idx = (i >= NUM_REQ) ? SEL_W'(i - NUM_REQ) : SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared-register write arbiter.
// Shares one DATA_W-bit register between NUM_REQ requesters. One requester
// is granted at a time in round-robin order; its data is loaded into the
// register one cycle after the grant, provided it still holds its request.
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of shared_reg_arbiter_if
//        (req, wdata in; gnt, done, owner, busy, q out)
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int                NUM_REQ   = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  shared_reg_arbiter_if.slave bus
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sr_state_t          state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               load;
  logic [DATA_W-1:0]  q_q;
  logic [DATA_W-1:0]  owner_data;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [MAX_REQ-1:0] pick_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req  (bus.req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Only the owner's slice can ever reach the register.
  always_comb begin
    owner_data = bus.wdata[int'(owner_q)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    load    = 1'b0;
    pick_oh = onehot(MAX_IDX_W'(pick_idx));
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_oh[NUM_REQ-1:0];
          owner_d = pick_idx;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        // The owner becomes lowest priority whether it commits or abandons.
        last_d = owner_q;
        if (bus.req[owner_q]) begin
          state_d = COMMIT;
          done_d  = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SEL_W'(NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // The shared register; reset discards any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else if (load) begin
      q_q <= owner_data;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_in_grant: assert property (@(posedge clk) disable iff (rst)
    (gnt_q != '0) |-> (state_q == GRANT));

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: stimulus predicts grants and
// commits from a transaction-level round-robin model and queues them; a
// negedge monitor pops and compares whenever the DUT shows gnt or done.
module tb_shared_reg_arbiter;

  localparam int        N  = 4;
  localparam int        DW = 8;
  localparam logic [7:0] RV = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shared_reg_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  shared_reg_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .RESET_VAL (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [7:0] data;
  } done_t;

  int    gnt_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_last  = N - 1;
  int         m_owner = 0;
  logic [7:0] m_q     = RV;
  bit         m_busy  = 1'b0;
  bit         m_done  = 1'b0;
  bit         m_gnt   = 1'b0;
  bit         running = 1'b0;

  logic [7:0] wd [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next requester after 'last' in circular order that is requesting.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic put_wdata();
    for (int k = 0; k < N; k++) bus.wdata[k*DW +: DW] = wd[k];
  endtask

  // One arbitration round, entered and left at posedge+2 with the DUT idle.
  task automatic round(input logic [N-1:0] r, input bit abandon, input bit disturb);
    int    w;
    done_t d;
    bus.req = r;
    put_wdata();
    if (r == '0) begin
      @(posedge clk); #2;
      return;
    end
    w = pick(r, m_last);
    gnt_q.push_back(w);
    @(posedge clk); #2;
    m_gnt   = 1'b1;
    m_busy  = 1'b1;
    m_owner = w;
    if (disturb) begin
      for (int k = 0; k < N; k++) if (k != w) wd[k] = 8'($urandom);
      put_wdata();
    end
    if (abandon) begin
      bus.req[w] = 1'b0;
    end else begin
      d.who  = w;
      d.data = wd[w];
      done_q.push_back(d);
    end
    @(posedge clk); #2;
    m_gnt  = 1'b0;
    m_last = w;
    if (abandon) begin
      m_busy = 1'b0;
      return;
    end
    m_q    = wd[w];
    m_done = 1'b1;
    if (disturb) begin
      for (int k = 0; k < N; k++) wd[k] = 8'($urandom);
      put_wdata();
      bus.req = N'($urandom);
    end
    @(posedge clk); #2;
    m_done = 1'b0;
    m_busy = 1'b0;
  endtask

  int    mon_w;
  done_t mon_d;

  always @(negedge clk) begin
    if (running && !rst) begin
      chk("gnt_onehot0", 32'($countones(bus.gnt) > 1), 32'd0);
      chk("gnt_active", 32'(bus.gnt != '0), 32'(m_gnt));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("owner", 32'(bus.owner), 32'(m_owner));
      chk("q", 32'(bus.q), 32'(m_q));
      if (bus.gnt != '0) begin
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
        end else begin
          mon_w = gnt_q.pop_front();
          chk("gnt_value", 32'(bus.gnt), 32'(1) << mon_w);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_owner", 32'(bus.owner), 32'(mon_d.who));
          chk("done_q", 32'(bus.q), 32'(mon_d.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.req = '0;
    for (int k = 0; k < N; k++) wd[k] = 8'h00;
    put_wdata();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_q", 32'(bus.q), 32'(RV));
    rst     = 1'b0;
    running = 1'b1;

    // Wrap-around from last=3: req 1001 grants 0 then 3
    wd[0] = 8'h10; wd[3] = 8'h13;
    round(4'b1001, 1'b0, 1'b0);
    chk("wrap_first_q", 32'(bus.q), 32'h10);
    round(4'b1001, 1'b0, 1'b0);
    chk("wrap_second_q", 32'(bus.q), 32'h13);

    // Fairness with all requesting: 0,1,2,3,0
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    for (int i = 0; i < 5; i++) round(4'b1111, 1'b0, 1'b0);
    chk("fair_last_owner", 32'(bus.owner), 32'd0);

    // Single request
    wd[2] = 8'hA5;
    round(4'b0100, 1'b0, 1'b0);
    chk("single_q", 32'(bus.q), 32'hA5);
    chk("single_owner", 32'(bus.owner), 32'd2);

    // Abandon by requester 3, then requester 0 follows
    wd[3] = 8'hEE; wd[0] = 8'h01;
    round(4'b1111, 1'b1, 1'b0);
    chk("abandon_q_held", 32'(bus.q), 32'hA5);
    round(4'b1111, 1'b0, 1'b0);
    chk("after_abandon_q", 32'(bus.q), 32'h01);

    // Non-owner isolation while requester 2 is granted
    wd[2] = 8'h3C;
    round(4'b0100, 1'b0, 1'b1);
    chk("isolate_owner", 32'(bus.owner), 32'd2);

    round(4'b0000, 1'b0, 1'b0);

    // Reset in the commit cycle with all requesting
    for (int k = 0; k < N; k++) wd[k] = 8'($urandom);
    put_wdata();
    bus.req = 4'b1111;
    w = pick(4'b1111, m_last);
    gnt_q.push_back(w);
    @(posedge clk); #2;
    m_gnt = 1'b1; m_busy = 1'b1; m_owner = w;
    @(posedge clk); #1;
    chk("pre_rst_done", 32'(bus.done), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_q", 32'(bus.q), 32'(RV));
    gnt_q.delete();
    done_q.delete();
    m_last = N - 1; m_owner = 0; m_q = RV;
    m_gnt = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    wd[0] = 8'h77;
    round(4'b1111, 1'b0, 1'b0);
    chk("post_rst_q", 32'(bus.q), 32'h77);

    // Randomized rounds
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < N; k++) wd[k] = 8'($urandom);
      round(N'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end

    bus.req = '0;
    @(posedge clk); #2;
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
